// File: rtl/id_stage_pipe_pkg.sv
// RV32I control-word types plus decode-stage helpers shared by id_stage_pipe.
// The illegal-funct7 constants are only consumed when ID_ILLEGAL_DETECT_EN is defined.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic {alumux1_rs1, alumux1_pc} alumux1_sel_t;
  typedef enum logic [2:0] {
    alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2
  } alumux2_sel_t;
  typedef enum logic {cmpmux_rs2, cmpmux_i_imm} cmpmux_sel_t;
  typedef enum logic [3:0] {
    rfmux_alu_out, rfmux_br_en, rfmux_u_imm, rfmux_lw, rfmux_pc_plus4,
    rfmux_lb, rfmux_lbu, rfmux_lh, rfmux_lhu
  } regfilemux_sel_t;

  typedef struct packed {
    logic [6:0]      opcode;
    alu_ops          aluop;
    logic [2:0]      cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            data_read;
    logic            data_write;
    logic [2:0]      mem_funct3;
    logic            load_regfile;
  } rv32i_control_word;
endpackage

package id_pkg;
  import rv32i_types::*;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

  localparam rv32i_control_word CTRL_NOP = rv32i_control_word'('0);
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction
endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero and write-through bypass.
module regfile_bypass #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr1_i,
  input  logic [$clog2(NREGS)-1:0] raddr2_i,
  output logic [XLEN-1:0]          rdata1_o,
  output logic [XLEN-1:0]          rdata2_o
);
  logic [XLEN-1:0] regs_q [NREGS];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (we_i && (raddr1_i != '0) && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (we_i && (raddr2_i != '0) && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
  end
endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined RV32I decode stage: decode, operand read, ID/EX register with handshake,
// load-use stall, flush and stall-time snoop. ID_ILLEGAL_DETECT_EN enables illegal-encoding flagging.
module id_stage_pipe
  import rv32i_types::*;
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     wb_load,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output rv32i_control_word        out_ctrl,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(NREGS)-1:0] out_rs1,
  output logic [$clog2(NREGS)-1:0] out_rs2,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic [XLEN-1:0]          out_rs1_data,
  output logic [XLEN-1:0]          out_rs2_data,
  output logic [XLEN-1:0]          out_imm,
  output logic                     hazard_stall,
  output logic                     out_illegal
);
  localparam int RA = $clog2(NREGS);

  logic [6:0]        opc;
  logic [2:0]        funct3;
  logic [RA-1:0]     rs1, rs2, rd;
  logic [XLEN-1:0]   rs1_rdata, rs2_rdata, dec_imm;
  rv32i_control_word ctrl, dec_ctrl;
  imm_fmt_t          fmt;
  logic              use_rs1, use_rs2, adv, hazard, accept;

  assign opc    = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[15 +: RA];
  assign rs2    = in_instr[20 +: RA];
  assign rd     = in_instr[7 +: RA];

  regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst_ni(rst), .we_i(wb_load), .waddr_i(wb_rd), .wdata_i(wb_data),
    .raddr1_i(rs1), .raddr2_i(rs2), .rdata1_o(rs1_rdata), .rdata2_o(rs2_rdata)
  );

  always_comb begin
    ctrl            = CTRL_NOP;
    ctrl.opcode     = opc;
    ctrl.mem_funct3 = funct3;
    fmt             = IMM_NONE;
    use_rs1         = 1'b0;
    use_rs2         = 1'b0;
    case (opc)
      op_lui: begin
        fmt = IMM_U; ctrl.load_regfile = 1'b1; ctrl.regfilemux_sel = rfmux_u_imm;
      end
      op_auipc: begin
        fmt = IMM_U; ctrl.load_regfile = 1'b1;
        ctrl.alumux1_sel = alumux1_pc; ctrl.alumux2_sel = alumux2_u_imm;
      end
      op_jal: begin
        fmt = IMM_J; ctrl.load_regfile = 1'b1; ctrl.regfilemux_sel = rfmux_pc_plus4;
        ctrl.alumux1_sel = alumux1_pc; ctrl.alumux2_sel = alumux2_j_imm;
      end
      op_jalr: begin
        fmt = IMM_I; use_rs1 = 1'b1; ctrl.load_regfile = 1'b1;
        ctrl.regfilemux_sel = rfmux_pc_plus4; ctrl.alumux2_sel = alumux2_i_imm;
      end
      op_br: begin
        fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl.cmpop = funct3;
        ctrl.alumux1_sel = alumux1_pc; ctrl.alumux2_sel = alumux2_b_imm;
      end
      op_load: begin
        fmt = IMM_I; use_rs1 = 1'b1; ctrl.load_regfile = 1'b1; ctrl.data_read = 1'b1;
        ctrl.alumux2_sel = alumux2_i_imm;
        case (funct3)
          3'b000:  ctrl.regfilemux_sel = rfmux_lb;
          3'b001:  ctrl.regfilemux_sel = rfmux_lh;
          3'b100:  ctrl.regfilemux_sel = rfmux_lbu;
          3'b101:  ctrl.regfilemux_sel = rfmux_lhu;
          default: ctrl.regfilemux_sel = rfmux_lw;
        endcase
      end
      op_store: begin
        fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl.data_write = 1'b1;
        ctrl.alumux2_sel = alumux2_s_imm;
      end
      op_imm, op_reg: begin
        use_rs1 = 1'b1; ctrl.load_regfile = 1'b1; ctrl.aluop = alu_ops'(funct3);
        if (opc == op_reg) begin
          use_rs2 = 1'b1; ctrl.alumux2_sel = alumux2_rs2;
        end else begin
          fmt = IMM_I; ctrl.alumux2_sel = alumux2_i_imm; ctrl.cmpmux_sel = cmpmux_i_imm;
        end
        case (funct3)
          3'b000: if ((opc == op_reg) && in_instr[30]) ctrl.aluop = alu_sub;
          3'b010: begin ctrl.cmpop = blt;  ctrl.regfilemux_sel = rfmux_br_en; end
          3'b011: begin ctrl.cmpop = bltu; ctrl.regfilemux_sel = rfmux_br_en; end
          3'b101: if (in_instr[30]) ctrl.aluop = alu_sra;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign dec_imm = XLEN'($signed(imm_gen(in_instr, fmt)));

`ifdef ID_ILLEGAL_DETECT_EN
  logic [6:0] funct7;
  logic       illegal;
  assign funct7 = in_instr[31:25];

  always_comb begin
    illegal = 1'b0;
    case (opc)
      op_lui, op_auipc, op_jal: illegal = 1'b0;
      op_jalr:  illegal = (funct3 != 3'b000);
      op_br:    illegal = (funct3[2:1] == 2'b01);
      op_load:  illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      op_store: illegal = funct3[2] || (funct3 == 3'b011);
      op_imm:   illegal = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                          ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      op_reg:   illegal = !((funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      default:  illegal = 1'b1;
    endcase
  end
  assign dec_ctrl = illegal ? CTRL_NOP : ctrl;
`else
  assign dec_ctrl = ctrl;
`endif

  logic                 valid_q, valid_d;
  rv32i_control_word    ctrl_q, ctrl_d;
  logic [XLEN-1:0]      pc_q, pc_d, d1_q, d1_d, d2_q, d2_d, imm_q, imm_d;
  logic [RA-1:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

  assign adv    = !valid_q || out_ready;
  // Flush overrides the load-use check so a redirect is never held back by a stale load.
  assign hazard = !flush && valid_q && (ctrl_q.opcode == op_load) && (rd_q != '0) && in_valid &&
                  ((use_rs1 && (rs1 == rd_q)) || (use_rs2 && (rs2 == rd_q)));
  assign in_ready = flush || (adv && !hazard);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q; ctrl_d = ctrl_q; pc_d = pc_q; imm_d = imm_q;
    rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q; d1_d = d1_q; d2_d = d2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1; ctrl_d = dec_ctrl; pc_d = in_pc; imm_d = dec_imm;
      rs1_d = rs1; rs2_d = rs2; rd_d = rd; d1_d = rs1_rdata; d2_d = rs2_rdata;
    end else if (adv) begin
      valid_d = 1'b0;
    end else if (wb_load && (wb_rd != '0)) begin
      if (wb_rd == rs1_q) d1_d = wb_data;
      if (wb_rd == rs2_q) d2_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0; ctrl_q <= CTRL_NOP; pc_q <= '0; imm_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0; d1_q <= '0; d2_q <= '0;
    end else begin
      valid_q <= valid_d; ctrl_q <= ctrl_d; pc_q <= pc_d; imm_q <= imm_d;
      rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d; d1_q <= d1_d; d2_q <= d2_d;
    end
  end

`ifdef ID_ILLEGAL_DETECT_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        illegal_q <= 1'b0;
    else if (flush)  illegal_q <= illegal_q;
    else if (accept) illegal_q <= illegal;
  end
  assign out_illegal = illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid    = valid_q;
  assign out_ctrl     = ctrl_q;
  assign out_pc       = pc_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_rs1_data = d1_q;
  assign out_rs2_data = d2_q;
  assign out_imm      = imm_q;
  assign hazard_stall = hazard;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a per-cycle reference model checked on every falling edge,
// plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  import rv32i_types::*;

`ifdef ID_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0, wb_load = 1'b0;
  logic [31:0] in_instr = 32'h0, in_pc = 32'h0, wb_data = 32'h0;
  logic [4:0]  wb_rd = 5'd0;
  logic in_ready, out_valid, hazard_stall, out_illegal;
  rv32i_control_word out_ctrl;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data), .out_ctrl(out_ctrl),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .hazard_stall(hazard_stall), .out_illegal(out_illegal)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: only the properties the bench checks, derived from the ISA encoding.
  typedef struct {
    logic [31:0] imm;
    bit lr, rd_en, wr_en, ld, u1, u2, ill;
  } dec_t;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? v - (32'd1 << bits) : v;
  endfunction

  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t d;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    d.imm = 32'h0; d.lr = 0; d.rd_en = 0; d.wr_en = 0; d.ld = 0; d.u1 = 0; d.u2 = 0; d.ill = 0;
    case (ins[6:0])
      7'h37, 7'h17: begin d.imm = {ins[31:12], 12'h0}; d.lr = 1; end
      7'h6F: begin d.imm = sext({11'h0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21); d.lr = 1; end
      7'h67: begin d.imm = sext({20'h0, ins[31:20]}, 12); d.lr = 1; d.u1 = 1; d.ill = (f3 != 0); end
      7'h63: begin
        d.imm = sext({19'h0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        d.u1 = 1; d.u2 = 1; d.ill = (f3 == 2) || (f3 == 3);
      end
      7'h03: begin
        d.imm = sext({20'h0, ins[31:20]}, 12); d.lr = 1; d.rd_en = 1; d.ld = 1; d.u1 = 1;
        d.ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
      end
      7'h23: begin
        d.imm = sext({20'h0, ins[31:25], ins[11:7]}, 12); d.wr_en = 1; d.u1 = 1; d.u2 = 1;
        d.ill = (f3 > 2);
      end
      7'h13: begin
        d.imm = sext({20'h0, ins[31:20]}, 12); d.lr = 1; d.u1 = 1;
        d.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'h33: begin
        d.lr = 1; d.u1 = 1; d.u2 = 1;
        d.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      default: d.ill = 1;
    endcase
    if (!ILL_EN) d.ill = 0;
    else if (d.ill) begin d.lr = 0; d.rd_en = 0; d.wr_en = 0; d.ld = 0; end
    return d;
  endfunction

  logic [31:0] rf [32];
  bit          m_valid;
  logic [31:0] m_pc, m_d1, m_d2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  dec_t        m_dec, c_di;
  logic [4:0]  c_r1, c_r2;
  bit          c_adv, c_haz, c_rdy;

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_load && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  // Inputs change just after each rising edge, so at the falling edge they are the values
  // the next rising edge will sample.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      m_valid = 0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    end else begin
      c_di  = model_decode(in_instr);
      c_r1  = in_instr[19:15];
      c_r2  = in_instr[24:20];
      c_adv = !m_valid || out_ready;
      c_haz = !flush && m_valid && m_dec.ld && m_rd != 0 && in_valid &&
              ((c_di.u1 && c_r1 == m_rd) || (c_di.u2 && c_r2 == m_rd));
      c_rdy = flush || (c_adv && !c_haz);

      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_rs1", out_rs1, m_rs1);
        chk("out_rs2", out_rs2, m_rs2);
        chk("out_rd", out_rd, m_rd);
        chk("out_rs1_data", out_rs1_data, m_d1);
        chk("out_rs2_data", out_rs2_data, m_d2);
        chk("out_imm", out_imm, m_dec.imm);
        chk("load_regfile", out_ctrl.load_regfile, m_dec.lr);
        chk("data_read", out_ctrl.data_read, m_dec.rd_en);
        chk("data_write", out_ctrl.data_write, m_dec.wr_en);
        chk("out_illegal", out_illegal, m_dec.ill);
      end
      chk("in_ready", in_ready, c_rdy);
      chk("hazard_stall", hazard_stall, c_haz);

      if (flush) m_valid = 0;
      else if (in_valid && c_rdy) begin
        m_valid = 1; m_pc = in_pc; m_rs1 = c_r1; m_rs2 = c_r2; m_rd = in_instr[11:7];
        m_d1 = rf_read(c_r1); m_d2 = rf_read(c_r2); m_dec = c_di;
      end else if (c_adv) m_valid = 0;
      else if (wb_load && wb_rd != 0) begin
        if (wb_rd == m_rs1) m_d1 = wb_data;
        if (wb_rd == m_rs2) m_d2 = wb_data;
      end
      if (wb_load && wb_rd != 0) rf[wb_rd] = wb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rs1_data", out_rs1_data, 0);
    chk("rst_load_regfile", out_ctrl.load_regfile, 0);
    chk("rst_data_read", out_ctrl.data_read, 0);
    rst = 1'b1;
    tick();

    // add x4,x3,x3 with no writeback
    issue(32'h00318233, 32'h100);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_rs1_data", out_rs1_data, 0);
    chk("t1_rs2_data", out_rs2_data, 0);
    chk("t1_load_regfile", out_ctrl.load_regfile, 1);

    // same add accepted while x3 is written back
    issue(32'h00318233, 32'h104);
    wb_load = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    wb_load = 1'b0;
    chk("t2_rs1_data", out_rs1_data, 32'hDEADBEEF);
    chk("t2_rs2_data", out_rs2_data, 32'hDEADBEEF);

    // lw x5,0(x1) followed by dependent add x6,x5,x2
    issue(32'h0000A283, 32'h108);
    tick();
    chk("t3_lw_read", out_ctrl.data_read, 1);
    issue(32'h00228333, 32'h10C);
    #1;
    chk("t3_hazard", hazard_stall, 1);
    chk("t3_in_ready", in_ready, 0);
    tick();
    chk("t3_bubble", out_valid, 0);
    chk("t3_hazard_gone", hazard_stall, 0);
    tick();
    chk("t3_add_valid", out_valid, 1);
    chk("t3_add_rs1", out_rs1, 5);
    chk("t3_add_pc", out_pc, 32'h10C);

    // add x7,x8,x9 held three cycles, x8 written back in the second
    issue(32'h009403B3, 32'h110);
    tick();
    out_ready = 1'b0;
    issue(32'hFFF00093, 32'h114);
    tick();
    wb_load = 1'b1; wb_rd = 5'd8; wb_data = 32'h55;
    tick();
    wb_load = 1'b0;
    tick();
    chk("t4_rs1_data", out_rs1_data, 32'h55);
    chk("t4_rs2_data", out_rs2_data, 0);
    chk("t4_rd", out_rd, 7);
    chk("t4_pc", out_pc, 32'h110);
    chk("t4_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("t4_addi_imm", out_imm, 32'hFFFFFFFF);
    chk("t4_addi_rd", out_rd, 1);

    issue(32'h0020A423, 32'h118);   // sw x2,8(x1)
    tick();
    chk("sw_imm", out_imm, 32'h8);
    chk("sw_write", out_ctrl.data_write, 1);
    issue(32'hFE208EE3, 32'h11C);   // beq x1,x2,-4
    tick();
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    issue(32'h12345537, 32'h120);   // lui x10,0x12345
    tick();
    chk("lui_imm", out_imm, 32'h12345000);
    issue(32'h008000EF, 32'h124);   // jal x1,+8
    tick();
    chk("jal_imm", out_imm, 32'h8);

    // flush while holding and receiving, with writes to x0 and x3 during flush
    issue(32'h00318233, 32'h130);
    tick();
    flush = 1'b1;
    issue(32'h12345537, 32'h134);
    wb_load = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    chk("t5_in_ready", in_ready, 1);
    tick();
    chk("t5_flushed", out_valid, 0);
    wb_rd = 5'd3; wb_data = 32'h77;
    tick();
    flush = 1'b0; wb_load = 1'b0;
    issue(32'h00300233, 32'h138);   // add x4,x0,x3
    tick();
    chk("t5_x0", out_rs1_data, 0);
    chk("t5_x3", out_rs2_data, 32'h77);

    // illegal encodings
    issue(32'h0000007F, 32'h13C);
    tick();
    chk("ill_flag", out_illegal, ILL_EN);
    chk("ill_load_regfile", out_ctrl.load_regfile, 0);
    chk("ill_data_write", out_ctrl.data_write, 0);
    issue(32'h02318233, 32'h140);   // op_reg with funct7=0x01
    tick();
    chk("ill_f7_lr", out_ctrl.load_regfile, !ILL_EN);
    issue(32'h0000B283, 32'h144);   // load funct3=3 then a consumer of x5
    tick();
    issue(32'h00228333, 32'h148);
    repeat (3) tick();

    in_valid = 1'b0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
